// File: rtl/keypad_scanner.sv
// Keypad matrix scanner: one-hot column drive, two-flop row synchroniser,
// press/release debounce and optional auto-repeat, one key_valid pulse per event.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 10000,
  parameter int REPEAT   = 0,
  parameter int CODE_W   = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              enable,
  input  logic [ROWS-1:0]   read_row,
  output logic [COLS-1:0]   scan_col,
  output logic              key_valid,
  output logic              key_repeat,
  output logic [CODE_W-1:0] key_code,
  output logic [ROWS-1:0]   key_row,
  output logic [COLS-1:0]   key_col,
  output logic              key_multi,
  output logic              key_held
);

  // state     | meaning
  // IDLE      | columns off, waiting for enable
  // SCAN      | stepping the one-hot column every SCAN_DIV cycles
  // DEB_PRESS | captured row pattern must stay stable for DEBOUNCE cycles
  // PRESS     | one-cycle key event
  // HOLD      | key down, auto-repeat timer running
  // RELEASE   | rows idle, must stay clear for DEBOUNCE cycles

  localparam int CNT_MAX = (DEBOUNCE > REPEAT) ? ((DEBOUNCE > 2) ? DEBOUNCE : 2)
                                               : ((REPEAT > 2) ? REPEAT : 2);
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CLR_W = $clog2(COLS + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'((REPEAT > 0) ? REPEAT - 1 : 0);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(COLS - 1);
  localparam logic [COLS-1:0]  COL_FIRST = {1'b1, {(COLS-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DEB_PRESS,
    PRESS,
    HOLD,
    RELEASE
  } state_t;

  state_t            state, nxt_state;
  logic [ROWS-1:0]   row_m, row_s;
  logic [DIV_W-1:0]  div, nxt_div;
  logic [CNT_W-1:0]  deb, nxt_deb;
  logic [CNT_W-1:0]  rpt, nxt_rpt;
  logic [CLR_W-1:0]  clr_cnt, nxt_clr_cnt;
  logic              armed, nxt_armed;
  logic [COLS-1:0]   nxt_scan_col;
  logic [ROWS-1:0]   nxt_key_row;
  logic [COLS-1:0]   nxt_key_col;
  logic [CODE_W-1:0] nxt_key_code;
  logic              nxt_key_multi;
  logic [COLS-1:0]   col_rot;

  function automatic logic [CODE_W-1:0] make_code(input logic [ROWS-1:0] rows,
                                                  input logic [COLS-1:0] cols);
    int r_idx;
    int c_idx;
    r_idx = 0;
    c_idx = 0;
    for (int i = 0; i < ROWS; i++) if (rows[i]) r_idx = i;
    for (int j = 0; j < COLS; j++) if (cols[j]) c_idx = j;
    return CODE_W'(r_idx * COLS + c_idx);
  endfunction

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      row_m <= '0;
      row_s <= '0;
    end else begin
      row_m <= read_row;
      row_s <= row_m;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      div       <= '0;
      deb       <= '0;
      rpt       <= '0;
      clr_cnt   <= '0;
      armed     <= 1'b0;
      scan_col  <= '0;
      key_row   <= '0;
      key_col   <= '0;
      key_code  <= '0;
      key_multi <= 1'b0;
    end else begin
      state     <= nxt_state;
      div       <= nxt_div;
      deb       <= nxt_deb;
      rpt       <= nxt_rpt;
      clr_cnt   <= nxt_clr_cnt;
      armed     <= nxt_armed;
      scan_col  <= nxt_scan_col;
      key_row   <= nxt_key_row;
      key_col   <= nxt_key_col;
      key_code  <= nxt_key_code;
      key_multi <= nxt_key_multi;
    end
  end

  assign col_rot  = {scan_col[0], scan_col[COLS-1:1]};
  assign key_held = (state == HOLD) || (state == RELEASE);

  always_comb begin
    nxt_state     = state;
    nxt_div       = '0;
    nxt_deb       = deb;
    nxt_rpt       = rpt;
    nxt_clr_cnt   = clr_cnt;
    nxt_armed     = armed;
    nxt_scan_col  = scan_col;
    nxt_key_row   = key_row;
    nxt_key_col   = key_col;
    nxt_key_code  = key_code;
    nxt_key_multi = key_multi;
    key_valid     = 1'b0;
    key_repeat    = 1'b0;

    if (!enable) begin
      nxt_state    = IDLE;
      nxt_scan_col = '0;
      nxt_deb      = '0;
      nxt_rpt      = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_scan_col = COL_FIRST;
          nxt_state    = SCAN;
        end

        SCAN: begin
          if (div == DIV_LAST) begin
            if (armed && (row_s != '0)) begin
              nxt_key_row = row_s;
              nxt_key_col = scan_col;
              nxt_deb     = '0;
              nxt_state   = DEB_PRESS;
            end else begin
              nxt_scan_col = col_rot;
              // After reset a key only counts once a full sweep has read clear
              if (!armed) begin
                if (row_s != '0)            nxt_clr_cnt = '0;
                else if (clr_cnt == CLR_LAST) nxt_armed = 1'b1;
                else                         nxt_clr_cnt = clr_cnt + 1'b1;
              end
            end
          end else begin
            nxt_div = div + 1'b1;
          end
        end

        DEB_PRESS: begin
          if (row_s != key_row) begin
            nxt_state = SCAN;
          end else if (deb == DEB_LAST) begin
            nxt_key_code  = make_code(key_row, key_col);
            nxt_key_multi = ($countones(key_row) > 1);
            nxt_state     = PRESS;
          end else begin
            nxt_deb = deb + 1'b1;
          end
        end

        PRESS: begin
          key_valid = 1'b1;
          nxt_deb   = '0;
          nxt_rpt   = '0;
          nxt_state = HOLD;
        end

        HOLD: begin
          if (row_s == '0) begin
            nxt_deb   = '0;
            nxt_state = RELEASE;
          end else if (REPEAT > 0) begin
            if (rpt == RPT_LAST) begin
              key_valid  = 1'b1;
              key_repeat = 1'b1;
              nxt_rpt    = '0;
            end else begin
              nxt_rpt = rpt + 1'b1;
            end
          end
        end

        RELEASE: begin
          if (row_s != '0) begin
            nxt_state = HOLD;
          end else if (deb == DEB_LAST) begin
            nxt_scan_col = col_rot;
            nxt_state    = SCAN;
          end else begin
            nxt_deb = deb + 1'b1;
          end
        end

        default: nxt_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model answers the column drive, expected
// key events go through a scoreboard queue and are compared on key_valid.
module tb_keypad_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;
  localparam int REPEAT   = 32;
  localparam int CODE_W   = 4;

  typedef struct {
    int           code;
    logic [3:0]   row;
    logic [3:0]   col;
    logic         multi;
    logic         rep;
    int           due;
  } ev_t;

  logic              clk = 1'b0;
  logic              nRst;
  logic              enable;
  logic [ROWS-1:0]   read_row;
  logic [COLS-1:0]   scan_col;
  logic              key_valid;
  logic              key_repeat;
  logic [CODE_W-1:0] key_code;
  logic [ROWS-1:0]   key_row;
  logic [COLS-1:0]   key_col;
  logic              key_multi;
  logic              key_held;

  logic [3:0] kp_col;
  logic [3:0] kp_rows;
  logic       kp_bounce;
  logic [19:0] all_outs;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  ev_t q[$];
  ev_t mon_e;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .REPEAT(REPEAT)
  ) dut (
    .clk(clk), .nRst(nRst), .enable(enable), .read_row(read_row),
    .scan_col(scan_col), .key_valid(key_valid), .key_repeat(key_repeat),
    .key_code(key_code), .key_row(key_row), .key_col(key_col),
    .key_multi(key_multi), .key_held(key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad: the pressed key connects its rows only while its column is driven
  assign read_row = (kp_bounce || ((scan_col & kp_col) == 4'b0000)) ? 4'b0000 : kp_rows;
  assign all_outs = {scan_col, key_valid, key_repeat, key_code, key_row, key_col, key_multi, key_held};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (key_repeat && !key_valid) check("repeat_without_valid", key_repeat, 1'b0);
    if (key_valid) begin
      if (q.size() == 0) begin
        check("unexpected_event", key_valid, 1'b0);
      end else begin
        mon_e = q.pop_front();
        check("ev_code", key_code, mon_e.code);
        check("ev_row", key_row, mon_e.row);
        check("ev_col", key_col, mon_e.col);
        check("ev_multi", key_multi, mon_e.multi);
        check("ev_repeat", key_repeat, mon_e.rep);
        if (mon_e.due >= 0) check("ev_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic wait_col(input logic [3:0] col, input string tag);
    for (int i = 0; i < 80 && scan_col != col; i++) @(negedge clk);
    check(tag, scan_col, col);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    check(tag, q.size(), 0);
  endtask

  // Key must be down before its column comes round; returns the expected press cycle
  task automatic press_key(input logic [3:0] col, input logic [3:0] rows,
                           input int code, input logic multi, output int p);
    logic [3:0] prev;
    ev_t e;
    prev = {col[2:0], col[3]};
    wait_col(prev, "reach_prev_col");
    kp_col = col;
    kp_rows = rows;
    kp_bounce = 1'b0;
    wait_col(col, "reach_key_col");
    p = cyc + SCAN_DIV - 1 + DEBOUNCE + 1;
    e = '{code: code, row: rows, col: col, multi: multi, rep: 1'b0, due: p};
    q.push_back(e);
  endtask

  task automatic release_key(input logic [3:0] next_col);
    int r;
    check("held_before_release", key_held, 1'b1);
    r = cyc;
    kp_col = 4'b0000;
    kp_rows = 4'b0000;
    kp_bounce = 1'b0;
    for (int i = 0; i < 40 && key_held; i++) @(negedge clk);
    check("release_latency", cyc, r + DEBOUNCE + 3);
    check("resume_col", scan_col, next_col);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    ev_t e;
    logic [3:0] exp_col;
    nRst = 1'b0;
    enable = 1'b0;
    kp_col = 4'b0000;
    kp_rows = 4'b0000;
    kp_bounce = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs, 20'h0);
    nRst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_col", scan_col, 4'b0000);
    end
    check("idle_outputs", all_outs, 20'h0);

    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp_col = 4'b1000 >> ((k / 4) % 4);
      check("scan_order", scan_col, exp_col);
    end

    // clean press: row 2 on column 1
    press_key(4'b0010, 4'b0100, 9, 1'b0, p);
    drain("clean_event", 40);
    repeat (3) @(negedge clk);
    release_key(4'b0001);

    // bouncing contact on column 3, row 0, then a short release glitch
    wait_col(4'b0001, "bounce_prev_col");
    kp_col = 4'b1000;
    kp_rows = 4'b0001;
    wait_col(4'b1000, "bounce_col");
    for (int i = 0; i < 20; i++) begin
      kp_bounce = ((i / 3) % 2) == 1;
      @(negedge clk);
    end
    kp_bounce = 1'b0;
    e = '{code: 3, row: 4'b0001, col: 4'b1000, multi: 1'b0, rep: 1'b0, due: -1};
    q.push_back(e);
    drain("bounce_event", 100);
    repeat (5) @(negedge clk);
    kp_bounce = 1'b1;
    repeat (2) @(negedge clk);
    kp_bounce = 1'b0;
    repeat (10) @(negedge clk);
    release_key(4'b0100);

    // auto-repeat: row 3 on column 0 held 100 cycles past the press
    press_key(4'b0001, 4'b1000, 12, 1'b0, p);
    for (int k = 1; k <= 3; k++) begin
      e = '{code: 12, row: 4'b1000, col: 4'b0001, multi: 1'b0, rep: 1'b1, due: p + REPEAT * k};
      q.push_back(e);
    end
    for (int i = 0; i < 400 && cyc < p + 100; i++) @(negedge clk);
    check("repeat_all_seen", q.size(), 0);
    release_key(4'b1000);

    // two rows together on column 2
    press_key(4'b0100, 4'b0110, 10, 1'b1, p);
    drain("multi_event", 40);
    repeat (3) @(negedge clk);
    release_key(4'b0010);

    // enable dropped during press debounce
    wait_col(4'b0010, "abort_prev_col");
    kp_col = 4'b0001;
    kp_rows = 4'b0001;
    wait_col(4'b0001, "abort_col");
    repeat (6) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_scan_off", scan_col, 4'b0000);
    check("abort_not_held", key_held, 1'b0);
    repeat (10) @(negedge clk);
    check("retained_code", key_code, 10);
    check("retained_multi", key_multi, 1'b1);

    // re-enable with key still down, then reset while it is held
    enable = 1'b1;
    press_key(4'b0001, 4'b0001, 0, 1'b0, p);
    drain("reenable_event", 60);
    repeat (4) @(negedge clk);
    #2 nRst = 1'b0;
    #1 check("reset_in_hold", all_outs, 20'h0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (60) @(negedge clk);
    check("held_through_reset", key_held, 1'b0);
    kp_col = 4'b0000;
    kp_rows = 4'b0000;
    repeat (40) @(negedge clk);
    press_key(4'b0010, 4'b0010, 5, 1'b0, p);
    drain("repress_event", 60);
    repeat (3) @(negedge clk);
    release_key(4'b0001);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
